// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter bundle: producer request slices, consumer
// back-pressure/flush, and the registered broadcast bus.
// slave  = arbiter side, master = producers/consumers side.
interface cdb_arbiter_if #(
    parameter int N_REQ      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_TAG_W  = 4,
    parameter int PREG_W     = 6
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*ROB_TAG_W-1:0]  req_rob_tag;
    logic [N_REQ*PREG_W-1:0]     req_preg;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_wr_reg;
    logic                        cdb_hold;
    logic                        flush;
    logic                        cdb_valid;
    logic [SRC_W-1:0]            cdb_src;
    logic [ROB_TAG_W-1:0]        cdb_rob_tag;
    logic [PREG_W-1:0]           cdb_preg;
    logic [DATA_WIDTH-1:0]       cdb_data;
    logic                        cdb_wr_reg;

    modport slave (
        input  req_valid, req_rob_tag, req_preg, req_data, req_wr_reg,
        input  cdb_hold, flush,
        output req_ready,
        output cdb_valid, cdb_src, cdb_rob_tag, cdb_preg, cdb_data, cdb_wr_reg
    );

    modport master (
        output req_valid, req_rob_tag, req_preg, req_data, req_wr_reg,
        output cdb_hold, flush,
        input  req_ready,
        input  cdb_valid, cdb_src, cdb_rob_tag, cdb_preg, cdb_data, cdb_wr_reg
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. One result per cycle is
// granted combinationally and broadcast from registers the next cycle.
// Optional per-requester conflict counters: define CDB_ARB_PERF_EN.
module cdb_arbiter #(
    parameter int N_REQ      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_TAG_W  = 4,
    parameter int PREG_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef CDB_ARB_PERF_EN
    output logic [N_REQ*16-1:0]   perf_conflict,
`endif
    cdb_arbiter_if.slave          bus
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [SRC_W-1:0]      rr_ptr;
    logic [N_REQ-1:0]      grant;
    logic                  found;
    logic [SRC_W:0]        scan;
    logic [SRC_W-1:0]      sel_src;
    logic [SRC_W-1:0]      next_ptr;
    logic [ROB_TAG_W-1:0]  sel_tag;
    logic [PREG_W-1:0]     sel_preg;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_wr;

    // Search from rr_ptr upward modulo N_REQ; reset, flush and hold block all grants
    always_comb begin
        grant = '0;
        found = 1'b0;
        scan  = '0;
        if (!rst && !bus.flush && !bus.cdb_hold) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
                if (scan >= (SRC_W+1)'(N_REQ)) begin
                    scan = scan - (SRC_W+1)'(N_REQ);
                end
                if (!found && bus.req_valid[scan[SRC_W-1:0]]) begin
                    grant[scan[SRC_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = grant;

    // Mux the winning requester's payload; grant is one-hot or zero
    always_comb begin
        sel_src  = '0;
        sel_tag  = '0;
        sel_preg = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_src  = SRC_W'(k);
                sel_tag  = bus.req_rob_tag[k*ROB_TAG_W +: ROB_TAG_W];
                sel_preg = bus.req_preg[k*PREG_W +: PREG_W];
                sel_data = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_wr   = bus.req_wr_reg[k];
            end
        end
        next_ptr = (sel_src == SRC_W'(N_REQ-1)) ? '0 : sel_src + 1'b1;
    end

    // Broadcast register and pointer; valid is a single-cycle pulse per transfer,
    // payload fields hold their last value when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            bus.cdb_valid   <= 1'b0;
            bus.cdb_src     <= '0;
            bus.cdb_rob_tag <= '0;
            bus.cdb_preg    <= '0;
            bus.cdb_data    <= '0;
            bus.cdb_wr_reg  <= 1'b0;
        end else begin
            bus.cdb_valid <= found;
            if (found) begin
                rr_ptr          <= next_ptr;
                bus.cdb_src     <= sel_src;
                bus.cdb_rob_tag <= sel_tag;
                bus.cdb_preg    <= sel_preg;
                bus.cdb_data    <= sel_data;
                bus.cdb_wr_reg  <= sel_wr;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic [15:0] conflict_cnt [N_REQ];

    // Saturating count of cycles a requester waited while the bus was not held
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                conflict_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (bus.req_valid[k] && !grant[k] && !bus.cdb_hold && conflict_cnt[k] != '1) begin
                    conflict_cnt[k] <= conflict_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Flatten the counters onto the perf port
    always_comb begin
        perf_conflict = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            perf_conflict[k*16 +: 16] = conflict_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a random
// run against a round-robin reference model.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ROB_TAG_W(TW), .PREG_W(PW)) bus ();
`ifdef CDB_ARB_PERF_EN
    logic [N*16-1:0] perf_conflict;
`endif

    cdb_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ROB_TAG_W(TW), .PREG_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef CDB_ARB_PERF_EN
        .perf_conflict (perf_conflict),
`endif
        .bus           (bus)
    );

    // Reference model state: what the broadcast bus must show after each edge
    int          m_ptr;
    logic        m_valid;
    int          m_src;
    logic [TW-1:0] m_tag;
    logic [PW-1:0] m_preg;
    logic [DW-1:0] m_data;
    logic        m_wr;

    function automatic int model_grant();
        if (rst || bus.flush || bus.cdb_hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w = model_grant();
        return (w < 0) ? '0 : (N'(1) << w);
    endfunction

    function automatic logic [45:0] obs_cdb();
        return {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_tag, bus.cdb_preg, bus.cdb_data, bus.cdb_wr_reg};
    endfunction

    function automatic logic [45:0] exp_cdb();
        return {m_valid, 2'(m_src), m_tag, m_preg, m_data, m_wr};
    endfunction

    // Advance the model with the current inputs, then cross one clock edge
    task automatic tick();
        int w = model_grant();
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_src = 0; m_tag = '0; m_preg = '0; m_data = '0; m_wr = 0;
        end else if (w >= 0) begin
            m_valid = 1;
            m_src   = w;
            m_tag   = bus.req_rob_tag[w*TW +: TW];
            m_preg  = bus.req_preg[w*PW +: PW];
            m_data  = bus.req_data[w*DW +: DW];
            m_wr    = bus.req_wr_reg[w];
            m_ptr   = (w + 1) % N;
        end else begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [TW-1:0] tag, input logic [PW-1:0] preg,
                           input logic [DW-1:0] data, input logic wr);
        bus.req_rob_tag[i*TW +: TW] = tag;
        bus.req_preg[i*PW +: PW]    = preg;
        bus.req_data[i*DW +: DW]    = data;
        bus.req_wr_reg[i]           = wr;
    endtask

    task automatic idle();
        rst = 0; bus.req_valid = '0; bus.cdb_hold = 0; bus.flush = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus.req_valid = 3'b111; bus.cdb_hold = 0; bus.flush = 0;
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 6'(i + 1), 32'(i + 1), 1'b1);
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 000", bus.req_ready);
        end
        tick(); tick();
        n_cmp++;
        if (obs_cdb() !== 46'd0) begin
            n_fail++; $display("FAIL reset_cdb: got %h want 0", obs_cdb());
        end
        n_cmp++;
        if (int'(dut.rr_ptr) !== 0) begin
            n_fail++; $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr);
        end
        idle();
    endtask

    task automatic test_single();
        bus.req_valid = 3'b001;
        set_req(0, 4'h5, 6'd12, 32'hDEADBEEF, 1'b1);
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++; $display("FAIL single_ready: got %b want 001", bus.req_ready);
        end
        tick();
        bus.req_valid = 3'b000;
        n_cmp++;
        if (obs_cdb() !== {1'b1, 2'd0, 4'h5, 6'd12, 32'hDEADBEEF, 1'b1}) begin
            n_fail++; $display("FAIL single_cdb: got %h want %h", obs_cdb(),
                {1'b1, 2'd0, 4'h5, 6'd12, 32'hDEADBEEF, 1'b1});
        end
        n_cmp++;
        if (int'(dut.rr_ptr) !== 1) begin
            n_fail++; $display("FAIL single_ptr: got %0d want 1", dut.rr_ptr);
        end
        tick();
        n_cmp++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_pulse: got valid %b data %h want 0 deadbeef",
                bus.cdb_valid, bus.cdb_data);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 6'(10 + i), 32'hA000_0000 + 32'(i), 1'b1);
        bus.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== (3'b001 << order[c])) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.req_ready, 3'b001 << order[c]);
            end
            tick();
            n_cmp++;
            if (bus.cdb_valid !== 1'b1 || int'(bus.cdb_src) !== order[c]
                || bus.cdb_data !== 32'hA000_0000 + 32'(order[c])) begin
                n_fail++; $display("FAIL rr_cdb[%0d]: got v%b src %0d data %h want v1 src %0d",
                    c, bus.cdb_valid, bus.cdb_src, bus.cdb_data, order[c]);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req_valid = 3'b010;
        tick();
        bus.req_valid = 3'b101;
        for (int i = 0; i < N; i++) set_req(i, 4'(i), 6'(i), 32'hB000_0000 + 32'(i), 1'b0);
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b100) begin
            n_fail++; $display("FAIL wrap_first: got %b want 100", bus.req_ready);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b001 || int'(bus.cdb_src) !== 2) begin
            n_fail++; $display("FAIL wrap_second: got ready %b src %0d want 001 src 2", bus.req_ready, bus.cdb_src);
        end
        tick();
        n_cmp++;
        if (int'(dut.rr_ptr) !== 1 || int'(bus.cdb_src) !== 0) begin
            n_fail++; $display("FAIL wrap_ptr: got ptr %0d src %0d want 1 0", dut.rr_ptr, bus.cdb_src);
        end
        idle();
    endtask

    task automatic test_hold();
        do_reset();
        bus.req_valid = 3'b010;
        set_req(1, 4'h3, 6'd7, 32'h1, 1'b1);
        set_req(2, 4'h4, 6'd8, 32'h2, 1'b1);
        set_req(0, 4'h2, 6'd6, 32'h9, 1'b1);
        tick();
        n_cmp++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'h1) begin
            n_fail++; $display("FAIL hold_grant: got v%b data %h want v1 data 1", bus.cdb_valid, bus.cdb_data);
        end
        bus.req_valid = 3'b111;
        bus.cdb_hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 3'b000) begin
                n_fail++; $display("FAIL hold_ready[%0d]: got %b want 000", c, bus.req_ready);
            end
            tick();
            n_cmp++;
            if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'h1) begin
                n_fail++; $display("FAIL hold_cdb[%0d]: got v%b data %h want v0 data 1", c, bus.cdb_valid, bus.cdb_data);
            end
        end
        bus.cdb_hold = 0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b100) begin
            n_fail++; $display("FAIL hold_release: got %b want 100", bus.req_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        bus.req_valid = 3'b001;
        set_req(0, 4'h1, 6'd1, 32'hF00D, 1'b1);
        tick();
        bus.req_valid = 3'b111;
        bus.flush = 1;
        bus.cdb_hold = 1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b000) begin
            n_fail++; $display("FAIL flush_ready: got %b want 000", bus.req_ready);
        end
        bus.cdb_hold = 0;
        tick();
        n_cmp++;
        if (bus.cdb_valid !== 1'b0 || int'(dut.rr_ptr) !== 1) begin
            n_fail++; $display("FAIL flush_drop: got v%b ptr %0d want v0 ptr 1", bus.cdb_valid, dut.rr_ptr);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 3'b001;
        set_req(0, 4'hA, 6'd33, 32'h1234_5678, 1'b1);
        tick();
        rst = 1;
        #1;
        n_cmp++;
        if (bus.cdb_valid !== 1'b1 || bus.req_ready !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_pre: got v%b ready %b want v1 ready 000", bus.cdb_valid, bus.req_ready);
        end
        tick();
        n_cmp++;
        if (obs_cdb() !== 46'd0 || int'(dut.rr_ptr) !== 0) begin
            n_fail++; $display("FAIL rstmid_cdb: got %h ptr %0d want 0 0", obs_cdb(), dut.rr_ptr);
        end
        idle();
    endtask

    task automatic test_random();
        int last_w = -1;
        int wait_x [N];
        int w;
        do_reset();
        for (int i = 0; i < N; i++) wait_x[i] = 0;
        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            bus.cdb_hold = ($urandom_range(0, 99) < 15);
            bus.flush    = ($urandom_range(0, 99) < 8);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || last_w == i) begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    set_req(i, 4'($urandom), 6'($urandom), $urandom, 1'($urandom));
                    wait_x[i] = 0;
                end
            end
            #1;
            n_cmp++;
            if (bus.req_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, model_ready());
            end
            w = model_grant();
            for (int i = 0; i < N; i++) begin
                if (rst) wait_x[i] = 0;
                else if (w >= 0 && w != i && bus.req_valid[i]) wait_x[i]++;
            end
            tick();
            last_w = w;
            n_cmp++;
            if (obs_cdb() !== exp_cdb() || int'(dut.rr_ptr) !== m_ptr) begin
                n_fail++; $display("FAIL rand_cdb[%0d]: got %h ptr %0d want %h ptr %0d",
                    c, obs_cdb(), dut.rr_ptr, exp_cdb(), m_ptr);
            end
            for (int i = 0; i < N; i++) begin
                if (wait_x[i] > 0) begin
                    n_cmp++;
                    if (wait_x[i] >= N) begin
                        n_fail++; $display("FAIL rand_starve[%0d]: req %0d waited %0d transfers want < %0d",
                            c, i, wait_x[i], N);
                    end
                end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        bus.req_rob_tag = '0; bus.req_preg = '0; bus.req_data = '0; bus.req_wr_reg = '0;
        m_ptr = 0; m_valid = 0; m_src = 0; m_tag = '0; m_preg = '0; m_data = '0; m_wr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
